// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead add/sub unit.
package cla_pkg;

  localparam int unsigned DefWidth  = 32;
  localparam int unsigned DefStages = 4;
  // Widest operand the saturation helper can describe.
  localparam int unsigned MaxWidth  = 128;

  typedef struct packed {
    logic carry_out;
    logic overflow;
    logic lt;
    logic ltu;
    logic neq;
  } cla_flags_t;

  // Signed max (neg=0) or signed min (neg=1) for a given width, LSB-aligned.
  function automatic logic [MaxWidth-1:0] sat_limit(input int unsigned width, input logic neg);
    logic [MaxWidth-1:0] lim;
    lim = '0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i + 1 < width) begin
        lim[i] = ~neg;
      end else if (i + 1 == width) begin
        lim[i] = neg;
      end
    end
    return lim;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead slice; every carry is a flat
// generate/propagate sum of products rather than a ripple chain.
module cla_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;
  logic           acc;
  logic           pp;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    g   = a & b;
    p   = a ^ b;
    c   = '0;
    acc = 1'b0;
    pp  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < int'(SEG); i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
    sum  = p ^ c[SEG-1:0];
    cout = c[SEG];
    cmsb = c[SEG-1];
  end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead add/subtract with flags and a valid/ready handshake.
// One SEG-bit segment resolves per stage; the last stage register is the output.
// Optional saturation is enabled by defining CLA_ADDSUB_SAT_EN.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             subtract_ctrl,
`ifdef CLA_ADDSUB_SAT_EN
  input  logic             sat_ctrl,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             lt,
  output logic             ltu,
  output logic             neq
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned Last = STAGES - 1;

  logic adv;
  logic sat_in;

  // Per-stage registers; a/b/sub/sat are skew, res is de-skew.
  logic [STAGES-1:0] valid_q, valid_d, carry_q, carry_d, neq_q, neq_d;
  logic [STAGES-1:0] sub_q, sub_d, sat_q, sat_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  cla_flags_t        flags_q, flags_d;

  // Stage inputs: the ports for stage 0, the previous stage register otherwise.
  logic [STAGES-1:0] st_valid, st_sub, st_sat, st_cin, st_neq;
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_res [STAGES];
  logic [SEG-1:0]    seg_sum [STAGES];
  logic [STAGES-1:0] seg_cout, seg_cmsb;
  logic              ovf;
  logic              msb;

`ifdef CLA_ADDSUB_SAT_EN
  assign sat_in = sat_ctrl;
`else
  assign sat_in = 1'b0;
`endif

  // A full output that is not being drained freezes the whole pipe, bubbles included.
  assign adv      = ~valid_q[Last] | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign st_valid[k] = in_valid;
      assign st_a[k]     = input_a;
      assign st_b[k]     = input_b;
      assign st_sub[k]   = subtract_ctrl;
      assign st_sat[k]   = sat_in;
      assign st_cin[k]   = subtract_ctrl;
      assign st_neq[k]   = 1'b0;
      assign st_res[k]   = '0;
    end else begin : g_rest
      assign st_valid[k] = valid_q[k-1];
      assign st_a[k]     = a_q[k-1];
      assign st_b[k]     = b_q[k-1];
      assign st_sub[k]   = sub_q[k-1];
      assign st_sat[k]   = sat_q[k-1];
      assign st_cin[k]   = carry_q[k-1];
      assign st_neq[k]   = neq_q[k-1];
      assign st_res[k]   = res_q[k-1];
    end

    cla_segment #(
      .SEG (SEG)
    ) u_seg (
      .a    (st_a[k][k*SEG +: SEG]),
      .b    (st_b[k][k*SEG +: SEG] ^ {SEG{st_sub[k]}}),
      .cin  (st_cin[k]),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k]),
      .cmsb (seg_cmsb[k])
    );
  end

  // Next state: insert each segment result and derive the flags in the last stage.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      valid_d[k] = st_valid[k];
      a_d[k]     = st_a[k];
      b_d[k]     = st_b[k];
      sub_d[k]   = st_sub[k];
      sat_d[k]   = st_sat[k];
      carry_d[k] = seg_cout[k];
      neq_d[k]   = st_neq[k] | (st_a[k][k*SEG +: SEG] != st_b[k][k*SEG +: SEG]);
      res_d[k]   = st_res[k];
      res_d[k][k*SEG +: SEG] = seg_sum[k];
    end
    ovf = seg_cmsb[Last] ^ seg_cout[Last];
    msb = seg_sum[Last][SEG-1];
    flags_d.carry_out = seg_cout[Last];
    flags_d.overflow  = ovf;
    flags_d.lt        = st_sub[Last] & (ovf ^ msb);
    flags_d.ltu       = st_sub[Last] & ~seg_cout[Last];
    flags_d.neq       = neq_d[Last];
    // On overflow the wrapped sign is inverted: wrapped MSB=1 means a true positive.
    if (st_sat[Last] && ovf) begin
      res_d[Last] = WIDTH'(sat_limit(WIDTH, ~msb));
    end
  end

  // Stage registers advance together under the global enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      carry_q <= '0;
      neq_q   <= '0;
      sub_q   <= '0;
      sat_q   <= '0;
      flags_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      neq_q   <= neq_d;
      sub_q   <= sub_d;
      sat_q   <= sat_d;
      flags_q <= flags_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  assign out_valid = valid_q[Last];
  assign sum       = res_q[Last];
  assign carry_out = flags_q.carry_out;
  assign overflow  = flags_q.overflow;
  assign lt        = flags_q.lt;
  assign ltu       = flags_q.ltu;
  assign neq       = flags_q.neq;

endmodule
